// File: rtl/register_file.sv
// Two-read / one-write general-purpose register file; x0 reads as zero.
// Optional write-first forwarding on the read ports when REGFILE_BYPASS_EN is defined.
module register_file #(
  parameter int DATA_WIDTH = 20,
  parameter int REG_NUMBER = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_NUMBER-1:0] rs1,
  input  logic [REG_NUMBER-1:0] rs2,
  input  logic [REG_NUMBER-1:0] rd,
  input  logic                  reg_write,
  input  logic [DATA_WIDTH-1:0] data_rd,
  output logic [DATA_WIDTH-1:0] data_rs1,
  output logic [DATA_WIDTH-1:0] data_rs2
);

  localparam int NUM_REGS = 2 ** REG_NUMBER;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic                                wr_en;

  assign wr_en = reg_write && (rd != '0);

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      regs_d = '0;
    end else if (wr_en) begin
      regs_d[rd] = data_rd;
    end
    // x0 is never stored, so it cannot be corrupted by any write path
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    data_rs1 = regs_q[rs1];
    data_rs2 = regs_q[rs2];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is held off during reset so the ports show the cleared file
    if (!rst && wr_en && (rs1 == rd)) data_rs1 = data_rd;
    if (!rst && wr_en && (rs2 == rd)) data_rs2 = data_rd;
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default 20-bit x 32 config).
module tb_register_file;

  localparam int DW = 20;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1, rs2, rd;
  logic          reg_write;
  logic [DW-1:0] data_rd;
  logic [DW-1:0] data_rs1, data_rs2;

  int passed = 0;
  int total  = 0;

  register_file #(.DATA_WIDTH(DW), .REG_NUMBER(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .reg_write(reg_write),
    .data_rd  (data_rd),
    .data_rs1 (data_rs1),
    .data_rs2 (data_rs2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; reg_write = 1'b0; rd = '0; data_rd = '0;
    tick();
    for (int i = 0; i < 32; i++) begin
      rs1 = AW'(i); rs2 = AW'(31 - i);
      #1;
      total++;
      if (data_rs1 !== 20'h00000)
        $display("FAIL reset_rs1[%0d] got %h want 00000", i, data_rs1);
      else passed++;
      total++;
      if (data_rs2 !== 20'h00000)
        $display("FAIL reset_rs2[%0d] got %h want 00000", 31 - i, data_rs2);
      else passed++;
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    reg_write = 1'b1; rd = 5'd3; data_rd = 20'h00011;
    tick();
    rd = 5'd2; data_rd = 20'h0002A;
    tick();
    reg_write = 1'b0; rs1 = 5'd3; rs2 = 5'd2;
    #1;
    total++;
    if (data_rs1 !== 20'h00011) $display("FAIL wr_x3 got %h want 00011", data_rs1);
    else passed++;
    total++;
    if (data_rs2 !== 20'h0002A) $display("FAIL wr_x2 got %h want 0002a", data_rs2);
    else passed++;
  endtask

  task automatic test_sum_sweep();
    logic [DW-1:0] exp_tab [5];
    exp_tab = '{20'h00000, 20'h00000, 20'h0002A, 20'h00011, 20'h0003B};
    reg_write = 1'b1; rd = 5'd4; data_rd = data_rs1 + data_rs2;
    tick();
    reg_write = 1'b0; rs1 = 5'd4; rs2 = 5'd4;
    #1;
    total++;
    if (data_rs1 !== 20'h0003B) $display("FAIL same_addr_rs1 got %h want 0003b", data_rs1);
    else passed++;
    total++;
    if (data_rs2 !== 20'h0003B) $display("FAIL same_addr_rs2 got %h want 0003b", data_rs2);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      rs1 = AW'(i);
      #1;
      total++;
      if (data_rs1 !== exp_tab[i]) $display("FAIL sweep_x%0d got %h want %h", i, data_rs1, exp_tab[i]);
      else passed++;
    end
  endtask

  task automatic test_discard();
    reg_write = 1'b1; rd = 5'd0; data_rd = 20'hFFFFF;
    tick();
    reg_write = 1'b0; rs1 = 5'd0;
    #1;
    total++;
    if (data_rs1 !== 20'h00000) $display("FAIL x0_write got %h want 00000", data_rs1);
    else passed++;
    rd = 5'd5; data_rd = 20'hABCDE;
    tick();
    rs1 = 5'd5;
    #1;
    total++;
    if (data_rs1 !== 20'h00000) $display("FAIL we_low got %h want 00000", data_rs1);
    else passed++;
    // other registers untouched by the discarded writes
    rs2 = 5'd3;
    #1;
    total++;
    if (data_rs2 !== 20'h00011) $display("FAIL x3_intact got %h want 00011", data_rs2);
    else passed++;
  endtask

  task automatic test_reset_priority();
    reg_write = 1'b1; rd = 5'd7; data_rd = 20'h77777;
    tick();
    rst = 1'b1; data_rd = 20'h55555;
    tick();
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] addr;
      addr = (i == 0) ? 5'd2 : (i == 1) ? 5'd3 : 5'd7;
      rs1 = addr;
      #1;
      total++;
      if (data_rs1 !== 20'h00000) $display("FAIL rst_prio_x%0d got %h want 00000", addr, data_rs1);
      else passed++;
    end
    rst = 1'b0; reg_write = 1'b0;
  endtask

  task automatic test_read_during_write();
    logic [DW-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 20'h12345;
`else
    exp_pre = 20'h00000;
`endif
    rs1 = 5'd9; rs2 = 5'd8; rd = 5'd9; data_rd = 20'h12345; reg_write = 1'b1;
    #1;
    total++;
    if (data_rs1 !== exp_pre) $display("FAIL rdw_pre got %h want %h", data_rs1, exp_pre);
    else passed++;
    total++;
    if (data_rs2 !== 20'h00000) $display("FAIL rdw_other_port got %h want 00000", data_rs2);
    else passed++;
    tick();
    reg_write = 1'b0;
    #1;
    total++;
    if (data_rs1 !== 20'h12345) $display("FAIL rdw_post got %h want 12345", data_rs1);
    else passed++;
    // x0 never forwards
    rs1 = 5'd0; rd = 5'd0; data_rd = 20'hFFFFF; reg_write = 1'b1;
    #1;
    total++;
    if (data_rs1 !== 20'h00000) $display("FAIL x0_no_fwd got %h want 00000", data_rs1);
    else passed++;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic test_back_to_back();
    reg_write = 1'b1;
    rd = 5'd31; data_rd = 20'hFFFFF;
    tick();
    rd = 5'd30; data_rd = 20'h80001;
    tick();
    reg_write = 1'b0; rs1 = 5'd31; rs2 = 5'd30;
    #1;
    total++;
    if (data_rs1 !== 20'hFFFFF) $display("FAIL b2b_x31 got %h want fffff", data_rs1);
    else passed++;
    total++;
    if (data_rs2 !== 20'h80001) $display("FAIL b2b_x30 got %h want 80001", data_rs2);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; reg_write = 1'b0; rs1 = '0; rs2 = '0; rd = '0; data_rd = '0;
    #2;
    test_reset();
    test_write_read();
    test_sum_sweep();
    test_discard();
    test_reset_priority();
    test_read_during_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose register file for the pipelined core.
- Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- Register count is 2**REG_NUMBER; register 0 is hardwired to zero.
- Sits in the decode stage; writes come from writeback.

Parameters:
- DATA_WIDTH, 20, width of each register and of every data port.
- REG_NUMBER, 5, width of the register address; the file holds 2**REG_NUMBER registers (32 by default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1  input  REG_NUMBER  read address, port 1.
- rs2  input  REG_NUMBER  read address, port 2.
- rd  input  REG_NUMBER  write address.
- reg_write  input  1  write enable.
- data_rd  input  DATA_WIDTH  write data.
- data_rs1  output  DATA_WIDTH  read data for rs1.
- data_rs2  output  DATA_WIDTH  read data for rs2.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: at a rising clk edge with rst=1, every register clears to 0. Reset has priority over a simultaneous write. While rst is high, outputs reflect the cleared contents (all 0) from the first reset edge onward.
- Write: at a rising clk edge with rst=0, reg_write=1 and rd!=0, register[rd] <= data_rd. The new value is visible on the read ports after that edge (1-cycle write latency).
  - reg_write=0: no register changes.
  - rd=0: the write is silently discarded.
- Read: data_rs1 = register[rs1] and data_rs2 = register[rs2], combinational with zero latency.
  - Address 0 always reads 0.
  - rs1 and rs2 may be equal; both ports then return the same value.
- Read-during-write to the same address (feature off): the read returns the old value until the clock edge, then the new value.
- No X propagation after reset: every register holds a defined value once one reset edge has occurred.
- Arithmetic: none. Data is stored and returned bit-exact at DATA_WIDTH; no truncation or extension.
- All addresses 0..2**REG_NUMBER-1 are valid; there is no out-of-range case.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined: in the same cycle that reg_write=1, rd!=0 and rsN==rd, data_rsN returns data_rd combinationally (write-first forwarding). This applies independently to each read port. rd=0 never forwards. Register update timing is unchanged.
- When undefined: no forwarding; read-during-write returns the stored (old) value as described above.

Test Plan:
- Reset, then sweep rs1 over 0..31 with reg_write=0 -> data_rs1 = 0x00000 for every address; data_rs2 likewise.
- rst=0. Write x3=0x00011 and x2=0x0002A on consecutive edges; then set rs1=3, rs2=2 -> data_rs1=0x00011, data_rs2=0x0002A.
- Write x4 = data_rs1 + data_rs2 (0x0003B); then set rs1=rs2=4 -> both ports read 0x0003B. Sweep rs1 over 0..4 -> reads 0, 0, 0x2A, 0x11, 0x3B.
- Write rd=0 with data 0xFFFFF, reg_write=1 -> x0 still reads 0. Write x5=0xABCDE with reg_write=0 -> x5 still reads 0.
- After writing x2 and x3, hold reg_write=1, rd=7 with rst=1 for one edge -> x2, x3 and x7 all read 0.
- With REGFILE_BYPASS_EN: set rs1=rd=9, data_rd=0x12345, reg_write=1 -> data_rs1=0x12345 before the edge. Without the macro: data_rs1=0 before the edge and 0x12345 after it.
